// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : ID-stage hazard controller: load-use stall, branch flush and
//            multi-cycle MDU launch/wait with timeout for the 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_IsMDU,
    input  logic             BranchTaken,
    input  logic             mdu_done,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                  c_wait_w    = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_wait_w-1:0] wait_cnt_q, wait_cnt_d;
    logic                mdu_timeout_q, mdu_timeout_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic                w_load_use;

    assign w_load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                        ((IDEX_rt == IFID_rs) || (IFID_UsesRt && (IDEX_rt == IFID_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mdu_timeout_d = mdu_timeout_q;
        PCWrite       = 1'b1;
        IFIDWrite     = 1'b1;
        IDEX_Bubble   = 1'b0;
        IFID_Flush    = 1'b0;
        mdu_start     = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Load-use wins over a branch: the branch compared stale operands.
                if (w_load_use) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else if (BranchTaken) begin
                    IFID_Flush  = 1'b1;
                end else if (IFID_IsMDU) begin
                    mdu_start   = 1'b1;
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_Bubble = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = ST_MDU_WAIT;
                end
            end
            ST_MDU_WAIT: begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
                if (mdu_done) begin
                    state_d = ST_RELEASE;
                end else if (wait_cnt_q == c_wait_last) begin
                    mdu_timeout_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    wait_cnt_d = wait_cnt_q + c_wait_w'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            PCWrite     = 1'b1;
            IFIDWrite   = 1'b1;
            IDEX_Bubble = 1'b0;
            IFID_Flush  = 1'b0;
            mdu_start   = 1'b0;
        end

        stall_cycles_d = stall_cycles_q;
        if (!PCWrite && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mdu_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mdu_timeout_q  <= mdu_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mdu_timeout  = mdu_timeout_q;
    assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire
